// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: state encoding, PC increment and the
// default reset address, plus the layout of one prefetch buffer entry.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          ENTRY_W          = 64;

    // One buffered fetch: the address in the upper half, the word below it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Instruction addresses are word aligned, so the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch buffer between the fetch PC and decode. A power-of-two ring of
// entries whose pointers wrap naturally; flush empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       wr_data,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Entry storage carries no reset; a flush simply discards what is there.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; reset and flush both return to empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, a three-state run/halt machine and
// the prefetch buffer feeding decode. Redirects flush the buffer and retarget
// the PC ahead of everything else except reset.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_pc,
    input  logic [31:0] rom_instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misaligned
);

    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign push       = (state == RUN) && !halt && !redirect
                        && ((count != FULL_COUNT) || pop);

    assign wr_entry   = '{pc: pc, word: rom_instruction};
    assign rom_pc     = pc;
    assign inst_pc    = head_entry.pc;
    assign inst       = head_entry.word;

    // PC register: redirect target wins, otherwise advance on each push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= align_word(redirect_pc);
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    // Run/halt sequencing; a redirect freezes the state for that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!redirect) begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     state <= halt ? HALTED : RUN;
                HALTED:  state <= halt ? HALTED : RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // One-cycle flag for a redirect target with nonzero low address bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .count   (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus queues the expected fetch
// addresses, a negedge monitor pops and compares on every handshake.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_pc;
    logic [31:0] rom_instruction;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misaligned;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expQueue [$];

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rom_pc          (rom_pc),
        .rom_instruction (rom_instruction),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .misaligned      (misaligned)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Distinct word per address so a wrong ROM pairing shows up.
    function automatic logic [31:0] romWord(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC3A5, addr[31:16] ^ 16'h5A3C};
    endfunction

    // Combinational instruction ROM.
    assign rom_instruction = romWord(rom_pc);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic redir,
                                 input logic [31:0] redirPc, input logic haltIn,
                                 input logic ready);
        rst_n       = rstN;
        redirect    = redir;
        redirect_pc = redirPc;
        halt        = haltIn;
        inst_ready  = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each handshake must match the oldest expected pc.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (expQueue.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL spare_handshake: got pc %h, expected no handshake", inst_pc);
            end else begin
                logic [31:0] e;
                e = expQueue.pop_front();
                checkOutput("sb_inst_pc", inst_pc, e);
                checkOutput("sb_inst", inst, romWord(e));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("reset_valid", 32'(inst_valid), 32'd0);
        checkOutput("reset_rom_pc", rom_pc, 32'h0);
        checkOutput("reset_misaligned", 32'(misaligned), 32'd0);

        // Streaming start after reset release
        $display("[TB] streaming from reset");
        expQueue.push_back(32'h0);
        expQueue.push_back(32'h4);
        expQueue.push_back(32'h8);
        expQueue.push_back(32'hC);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("idle_edge_valid", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("first_valid", 32'(inst_valid), 32'd1);
        checkOutput("first_inst_pc", inst_pc, 32'h0);
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Backpressure: buffer fills to two entries and pc stalls at 8
        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("stall_rom_pc_a", rom_pc, 32'h8);
        tick();
        checkOutput("stall_rom_pc_b", rom_pc, 32'h8);
        checkOutput("stall_valid", 32'(inst_valid), 32'd1);
        checkOutput("stall_head_pc", inst_pc, 32'h0);
        expQueue.push_back(32'h0);
        expQueue.push_back(32'h4);
        expQueue.push_back(32'h8);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Aligned redirect while full
        $display("[TB] aligned redirect");
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        checkOutput("redir_flush_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_rom_pc", rom_pc, 32'h100);
        checkOutput("redir_misaligned", 32'(misaligned), 32'd0);
        expQueue.push_back(32'h100);
        expQueue.push_back(32'h104);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("redir_valid", 32'(inst_valid), 32'd1);
        checkOutput("redir_inst_pc", inst_pc, 32'h100);
        checkOutput("redir_misaligned_after", 32'(misaligned), 32'd0);
        tick();

        // Misaligned redirect, with a handshake in the redirect cycle
        $display("[TB] misaligned redirect");
        applyStimulus(1'b1, 1'b1, 32'h103, 1'b0, 1'b1);
        tick();
        checkOutput("mis_pulse", 32'(misaligned), 32'd1);
        checkOutput("mis_flush_valid", 32'(inst_valid), 32'd0);
        checkOutput("mis_rom_pc", rom_pc, 32'h100);
        expQueue.push_back(32'h100);
        expQueue.push_back(32'h104);
        expQueue.push_back(32'h108);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("mis_pulse_end", 32'(misaligned), 32'd0);
        checkOutput("mis_inst_pc", inst_pc, 32'h100);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Halt drains the buffer and freezes pc
        $display("[TB] halt");
        tick();
        checkOutput("prehalt_rom_pc", rom_pc, 32'h114);
        expQueue.push_back(32'h10C);
        expQueue.push_back(32'h110);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) tick();
        checkOutput("halt_drained", 32'(inst_valid), 32'd0);
        checkOutput("halt_rom_pc_a", rom_pc, 32'h114);
        repeat (2) tick();
        checkOutput("halt_still_empty", 32'(inst_valid), 32'd0);
        checkOutput("halt_rom_pc_b", rom_pc, 32'h114);
        expQueue.push_back(32'h114);
        expQueue.push_back(32'h118);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("resume_wait_valid", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("resume_inst_pc", inst_pc, 32'h114);
        repeat (2) tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Redirect while halted keeps the HALTED state
        $display("[TB] redirect while halted");
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        checkOutput("hredir_valid", 32'(inst_valid), 32'd0);
        checkOutput("hredir_rom_pc", rom_pc, 32'h200);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("hredir_still_halted", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("hredir_fetch_valid", 32'(inst_valid), 32'd1);
        checkOutput("hredir_inst_pc", inst_pc, 32'h200);

        // Reset overrides a simultaneous redirect
        $display("[TB] reset with redirect");
        applyStimulus(1'b0, 1'b1, 32'h301, 1'b1, 1'b0);
        tick();
        checkOutput("rst_rom_pc", rom_pc, 32'h0);
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_idle_valid", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("rst_fetch_pc", inst_pc, 32'h0);

        // PC wraps from the top of the address space
        $display("[TB] pc wrap");
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        checkOutput("wrap_rom_pc_top", rom_pc, 32'hFFFF_FFFC);
        expQueue.push_back(32'hFFFF_FFFC);
        expQueue.push_back(32'h0);
        expQueue.push_back(32'h4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("wrap_rom_pc_zero", rom_pc, 32'h0);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) tick();

        checkOutput("scoreboard_empty", 32'(expQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL be the prefetch buffer depth in entries; legal values are powers of two, 2 or greater.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 rom_pc  output  32  SHALL be the fetch address driven to the instruction ROM pc port.
REQ-006 rom_instruction  input  32  SHALL be the combinational ROM word for rom_pc, valid in the same cycle.
REQ-007 redirect  input  1  SHALL request a control-flow change; sampled each cycle.
REQ-008 redirect_pc  input  32  SHALL be the redirect target; valid only while redirect=1.
REQ-009 halt  input  1  SHALL stop new fetches while high.
REQ-010 inst_valid  output  1  SHALL indicate that inst/inst_pc hold a valid entry.
REQ-011 inst_ready  input  1  SHALL indicate that decode accepts the entry.
REQ-012 inst  output  32  SHALL be the instruction word at the FIFO head.
REQ-013 inst_pc  output  32  SHALL be the address of inst.
REQ-014 misaligned  output  1  SHALL be a registered one-cycle pulse flagging a redirect_pc with [1:0]!=0.

Function
REQ-015 A PC register SHALL drive rom_pc directly, with no combinational path from any input to rom_pc.
REQ-016 States SHALL be IDLE, RUN and HALTED; transitions: IDLE->RUN unconditionally after one cycle; RUN->HALTED when halt=1; HALTED->RUN when halt=0.
REQ-017 Push SHALL occur when state=RUN, halt=0, redirect=0 and (count<FIFO_DEPTH or pop).
REQ-018 A push SHALL write {pc, rom_instruction} into the FIFO and set pc<=pc+4 modulo 2^32, so that 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 Pop SHALL be inst_valid & inst_ready, and SHALL advance the FIFO head.
REQ-020 Push and pop SHALL both be allowed in the same cycle at any count, including full; count is then unchanged.
REQ-021 inst_valid SHALL equal (count!=0); inst/inst_pc SHALL come from registered FIFO storage.
REQ-022 Redirect SHALL have priority over push, halt and state transitions.
REQ-023 On redirect, the block SHALL in that cycle: flush the FIFO (count<=0), load pc<=redirect_pc with bits [1:0] forced to 0, and push nothing.
REQ-024 A handshake occurring in the same cycle as a redirect SHALL count as consumed.
REQ-025 Redirect-to-first-valid latency SHALL be 2 cycles: redirect at edge N, push of the target at edge N+1, inst_valid=1 with inst_pc=target after N+1.
REQ-026 When halt=1 (RUN->HALTED transition cycle or HALTED), pc SHALL hold and the FIFO SHALL continue to drain.
REQ-027 A redirect while HALTED SHALL flush the FIFO and load pc, and the state SHALL remain HALTED.
REQ-028 misaligned SHALL be 1 for exactly the cycle after a redirect with redirect_pc[1:0]!=0, and 0 otherwise.
REQ-029 With rst_n high, the first push SHALL occur at the 2nd rising edge after reset release (IDLE at the 1st).

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL set pc=RESET_PC, count=0, FIFO pointers=0, state=IDLE, inst_valid=0 and misaligned=0.
REQ-031 Reset SHALL override redirect, halt and any in-flight push or pop.
REQ-032 FIFO data storage SHALL need no reset; inst/inst_pc are don't-care while inst_valid=0.

Structure
REQ-033 The shared package cpu_pkg SHALL hold the fetch state enum (IDLE, RUN, HALTED), the PC_STEP=4 constant and the default RESET_PC.
REQ-034 The FIFO SHALL be a sub-module fetch_fifo (64-bit entry, parameter DEPTH, push/pop/flush, count output).
REQ-035 The PC register, state machine and control SHALL reside in instr_fetch.

Verification
REQ-036 Reset release, inst_ready=1 -> inst_valid first high after edge 2; inst_pc sequence 0,4,8,12 with inst = ROM words 0..3.
REQ-037 inst_ready=0 held 5 cycles -> exactly 2 entries buffered, pc=8, rom_pc stable; then inst_ready=1 -> pcs 0,4,8 delivered in order, none lost or duplicated.
REQ-038 redirect with redirect_pc=32'h100 while FIFO full -> inst_valid=0 the next cycle, inst_pc=32'h100 two cycles after redirect, misaligned stays 0.
REQ-039 redirect with redirect_pc=32'h103 -> misaligned pulses 1 cycle, first inst_pc=32'h100.
REQ-040 halt=1 for 4 cycles with inst_ready=1 -> FIFO drains to empty, pc frozen; halt=0 -> fetch resumes at the frozen pc.
REQ-041 rst_n=0 mid-stream with redirect=1 -> next cycle pc=RESET_PC, inst_valid=0, state IDLE.
